// File: rtl/audio_out_sequencer_if.sv
// Avalon-MM slave bus for the audio output sequencer.
// The CPU side uses the master modport and the sequencer uses the slave modport.
interface audio_out_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/audio_out_sequencer.sv
// Buffers CPU-written audio samples in a FIFO.
// Releases them to the codec at a fixed, divider-derived sample rate.
module audio_out_sequencer #(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5,
    parameter int DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    audio_out_sequencer_if.slave  bus,
    output logic [15:0]           out_port,
    output logic                  sample_stb,
    output logic                  irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(DEPTH / 2);

    logic [15:0]      mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [LVL_W-1:0] level;
    logic [DIV_W-1:0] div, cnt;
    logic             en, irq_en, underrun, overflow;

    logic wr, wr_data, wr_ctrl, wr_div, wr_stat;
    logic flush, tick, empty, full, pop, push_ok;
    logic unr_set, ovf_set;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_data = wr & (bus.address == 2'd0);
    assign wr_ctrl = wr & (bus.address == 2'd1);
    assign wr_div  = wr & (bus.address == 2'd2);
    assign wr_stat = wr & (bus.address == 2'd3);

    assign flush   = wr_ctrl & bus.writedata[2];
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign tick    = en & (cnt == div);
    assign pop     = tick & ~empty;
    // A pop frees the slot a same-cycle push into a full FIFO needs
    assign push_ok = wr_data & ~flush & (~full | pop);
    assign ovf_set = wr_data & ~flush & full & ~pop;
    assign unr_set = tick & empty;

    logic unused;
    assign unused = ^bus.writedata[31:18];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            div    <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ctrl) begin
                en     <= bus.writedata[0];
                irq_en <= bus.writedata[1];
            end
            if (wr_div)
                div <= bus.writedata[DIV_W-1:0];
            if (wr_div || !en || tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= bus.writedata[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            level <= level + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port   <= '0;
            sample_stb <= 1'b0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (pop)
                out_port <= mem[rptr];
            sample_stb <= pop;
            // Setting events take priority over a write-1-to-clear
            underrun <= unr_set | (underrun & ~(wr_stat & bus.writedata[16]));
            overflow <= ovf_set | (overflow & ~(wr_stat & bus.writedata[17]));
            irq      <= irq_en & ((level <= HALF_LVL) | underrun);
        end
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            2'd0: bus.readdata[15:0] = out_port;
            2'd1: bus.readdata[1:0] = {irq_en, en};
            2'd2: bus.readdata[DIV_W-1:0] = div;
            2'd3: begin
                bus.readdata[LVL_W-1:0] = level;
                bus.readdata[8]         = empty;
                bus.readdata[9]         = full;
                bus.readdata[16]        = underrun;
                bus.readdata[17]        = overflow;
            end
            default: bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_audio_out_sequencer.sv
// Directed bench for audio_out_sequencer.
// Bus writes are driven from a negedge and checks are taken at negedges.
module tb_audio_out_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] out_port;
    logic        sample_stb;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    audio_out_sequencer_if bus ();

    audio_out_sequencer #(.DEPTH(16), .LVL_W(5), .DIV_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .out_port   (out_port),
        .sample_stb (sample_stb),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    initial begin
        logic [15:0] exp_out;
        logic        exp_stb;

        reset_n        = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_stb", 32'(sample_stb), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk_rd("rst_data", 2'd0, 32'h0);
        chk_rd("rst_ctrl", 2'd1, 32'h0);
        chk_rd("rst_div", 2'd2, 32'h0);
        @(negedge clk);
        chk_rd("rst_status", 2'd3, 32'h100);

        // DIV=3 playback of three samples, then an underrun
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1111);
        wr(2'd0, 32'h2222);
        wr(2'd0, 32'h3333);
        chk_rd("div_rd", 2'd2, 32'd3);
        chk_rd("lvl3", 2'd3, 32'h3);
        wr(2'd1, 32'h1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_stb = (i % 4 == 3) && (i < 12);
            if (i < 3)       exp_out = 16'h0000;
            else if (i < 7)  exp_out = 16'h1111;
            else if (i < 11) exp_out = 16'h2222;
            else             exp_out = 16'h3333;
            chk($sformatf("play_stb%0d", i), 32'(sample_stb), 32'(exp_stb));
            chk($sformatf("play_out%0d", i), 32'(out_port), 32'(exp_out));
        end
        chk_rd("play_unr", 2'd3, 32'h10100);
        chk_rd("play_data", 2'd0, 32'h3333);
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h10000);
        chk_rd("unr_clr", 2'd3, 32'h100);

        // Overflow with en=0
        for (int i = 0; i < 17; i++)
            wr(2'd0, 32'h100 + 32'(i));
        chk_rd("ovf_set", 2'd3, 32'h20210);
        wr(2'd3, 32'h20000);
        chk_rd("ovf_clr", 2'd3, 32'h210);
        chk("ovf_irq", 32'(irq), 32'h0);

        // DIV=0: push while full on a pop cycle, then push on an empty tick
        wr(2'd2, 32'd0);
        wr(2'd1, 32'h1);
        wr(2'd0, 32'h0AAA);
        chk_rd("fullpp_st", 2'd3, 32'h210);
        chk("fullpp_out", 32'(out_port), 32'h0100);
        repeat (16) @(negedge clk);
        chk_rd("drain_st", 2'd3, 32'h100);
        chk("drain_out", 32'(out_port), 32'h0AAA);
        wr(2'd0, 32'h0BBB);
        chk_rd("emptypp_st", 2'd3, 32'h10001);
        wr(2'd1, 32'h0);
        chk("emptypp_out", 32'(out_port), 32'h0BBB);
        chk_rd("emptypp_st2", 2'd3, 32'h10100);
        wr(2'd3, 32'h10000);

        // irq threshold crossing 9 -> 8
        for (int i = 0; i < 9; i++)
            wr(2'd0, 32'h200 + 32'(i));
        wr(2'd1, 32'h2);
        wr(2'd1, 32'h3);
        wr(2'd1, 32'h2);
        chk_rd("irq_lvl8", 2'd3, 32'h8);
        chk("irq_lag", 32'(irq), 32'h0);
        chk("irq_pop_out", 32'(out_port), 32'h0200);
        @(negedge clk);
        chk("irq_assert", 32'(irq), 32'h1);
        for (int i = 0; i < 4; i++)
            wr(2'd0, 32'h300 + 32'(i));
        wr(2'd3, 32'h10000);
        chk_rd("irq_lvl12", 2'd3, 32'hC);
        chk("irq_low", 32'(irq), 32'h0);

        // Mid-stream flush
        wr(2'd2, 32'd3);
        wr(2'd1, 32'h3);
        repeat (5) @(negedge clk);
        chk("fl_pre_out", 32'(out_port), 32'h0201);
        chk_rd("fl_pre_st", 2'd3, 32'hB);
        wr(2'd1, 32'h7);
        chk_rd("fl_st", 2'd3, 32'h100);
        chk_rd("fl_ctrl", 2'd1, 32'h3);
        chk("fl_out", 32'(out_port), 32'h0201);
        @(negedge clk);
        chk_rd("fl_st2", 2'd3, 32'h100);
        @(negedge clk);
        chk_rd("fl_unr", 2'd3, 32'h10100);
        chk("fl_unr_out", 32'(out_port), 32'h0201);
        chk("fl_unr_stb", 32'(sample_stb), 32'h0);
        chk("fl_irq", 32'(irq), 32'h1);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_port), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_stb", 32'(sample_stb), 32'h0);
        chk_rd("arst_st", 2'd3, 32'h100);
        @(negedge clk);
        reset_n = 1'b1;
        chk_rd("arst_ctrl", 2'd1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
